// File: rtl/branch_resolve_ctrl_pkg.sv
// rtl/branch_resolve_ctrl_pkg.sv - shared encodings for the EX-stage branch resolver
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned PC_INCR = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // funct3 010/011 are the only unused codes in the branch major opcode
    function automatic logic f3_is_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_branch.sv
// rtl/branch_resolve_ctrl_branch.sv - RV64 conditional branch comparator
module branch_resolve_ctrl_branch
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      funct3_i,
    output logic            taken_o,
    output logic            illegal_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rs1_i == rs2_i);
            F3_BNE:  taken_o = (rs1_i != rs2_i);
            F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: taken_o = (rs1_i <  rs2_i);
            F3_BGEU: taken_o = (rs1_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end

    assign illegal_o = f3_is_illegal(funct3_i);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - EX-stage branch sequencer, redirect and timed flush; BRANCH_STATS_EN adds saturating counters
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int IALIGN       = 32,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_pc,
    input  logic [XLEN-1:0]  req_imm,
    input  logic             req_pred_taken,
    input  logic             flush_in,
    output logic             resolve_valid,
    output logic             resolve_taken,
    output logic [XLEN-1:0]  resolve_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_out,
    output logic             illegal_op,
    output logic             misalign,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [XLEN-1:0]   rs1_q, rs2_q, pc_q, imm_q;
    logic [2:0]        funct3_q;
    logic              pred_q;
    logic              accept;
    logic              taken;
    logic              illegal;
    logic [XLEN-1:0]   target;

    assign req_ready = (state_q == ST_IDLE) && !flush_in;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            funct3_q <= '0;
            pred_q   <= 1'b0;
        end else if (accept) begin
            rs1_q    <= req_rs1;
            rs2_q    <= req_rs2;
            pc_q     <= req_pc;
            imm_q    <= req_imm;
            funct3_q <= req_funct3;
            pred_q   <= req_pred_taken;
        end
    end

    branch_resolve_ctrl_branch #(.XLEN(XLEN)) u_branch (
        .rs1_i     (rs1_q),
        .rs2_i     (rs2_q),
        .funct3_i  (funct3_q),
        .taken_o   (taken),
        .illegal_o (illegal)
    );

    assign target = taken ? (pc_q + imm_q) : (pc_q + XLEN'(PC_INCR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // an external flush overrides every internal transition and abandons any flush countdown
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (flush_in) begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = ST_EVAL;
                ST_EVAL: begin
                    if (taken != pred_q) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q == '0) state_d = ST_IDLE;
                    else              fcnt_d  = fcnt_q - FC_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        resolve_valid  = 1'b0;
        resolve_taken  = 1'b0;
        resolve_target = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        illegal_op     = 1'b0;
        misalign       = 1'b0;
        flush_out      = 1'b0;
        case (state_q)
            ST_EVAL: begin
                if (!flush_in) begin
                    resolve_valid  = 1'b1;
                    resolve_taken  = taken;
                    resolve_target = target;
                    illegal_op     = illegal;
                    misalign       = taken && ((IALIGN == 16) ? target[0] : target[1]);
                    if (taken != pred_q) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = target;
                    end
                end
            end
            ST_FLUSH: flush_out = 1'b1;
            default: ;
        endcase
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (resolve_valid && !(&br_cnt_q))  br_cnt_d = br_cnt_q + CNT_W'(1);
        if (redirect_valid && !(&mp_cnt_q)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branches = br_cnt_q;
    assign stat_mispred  = mp_cnt_q;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed plus randomized bench for branch_resolve_ctrl against a behavioural model
module tb_branch_resolve_ctrl;

    localparam int XLEN         = 64;
    localparam int FLUSH_CYCLES = 2;
    localparam int IALIGN       = 32;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef BRANCH_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_rs1, req_rs2, req_pc, req_imm;
    logic [2:0]       req_funct3;
    logic             req_pred_taken;
    logic             flush_in;
    logic             resolve_valid, resolve_taken;
    logic [XLEN-1:0]  resolve_target;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_out, illegal_op, misalign;
    logic [CNT_W-1:0] stat_branches, stat_mispred;

    int checks = 0;
    int errors = 0;

    branch_resolve_ctrl #(
        .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .IALIGN(IALIGN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3),
        .req_pc(req_pc), .req_imm(req_imm), .req_pred_taken(req_pred_taken),
        .flush_in(flush_in),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_out(flush_out), .illegal_op(illegal_op), .misalign(misalign),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rs1, rs2, pc, imm;
        logic [2:0]  f3;
        logic        pred;
    } br_t;

    // model: one pending branch awaiting evaluation, plus remaining flush cycles
    br_t m_br;
    bit  m_eval;
    int  m_flush_left;
    int  m_nbr, m_nmp;
    bit  m_last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input br_t b);
        longint a, c;
        a = b.rs1;
        c = b.rs2;
        case (b.f3)
            3'd0:    return b.rs1 == b.rs2;
            3'd1:    return b.rs1 != b.rs2;
            3'd4:    return a < c;
            3'd5:    return a >= c;
            3'd6:    return b.rs1 < b.rs2;
            3'd7:    return b.rs1 >= b.rs2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_reset();
        m_br         = '{64'd0, 64'd0, 64'd0, 64'd0, 3'd0, 1'b0};
        m_eval       = 1'b0;
        m_flush_left = 0;
        m_nbr        = 0;
        m_nmp        = 0;
        m_last_acc   = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        acc = req_valid && !m_eval && (m_flush_left == 0) && !flush_in;
        m_last_acc = acc;
        if (flush_in) begin
            m_eval       = 1'b0;
            m_flush_left = 0;
        end else if (m_eval) begin
            m_nbr = sat_inc(m_nbr);
            if (ref_taken(m_br) != m_br.pred) begin
                m_nmp        = sat_inc(m_nmp);
                m_flush_left = FLUSH_CYCLES;
            end
            m_eval = 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
        if (acc) begin
            m_br   = '{req_rs1, req_rs2, req_pc, req_imm, req_funct3, req_pred_taken};
            m_eval = 1'b1;
        end
    endtask

    always @(negedge clk) begin : compare_proc
        bit          ev, t, mp;
        logic [63:0] tgt;
        ev  = m_eval && !flush_in;
        t   = ev && ref_taken(m_br);
        tgt = ev ? (t ? m_br.pc + m_br.imm : m_br.pc + 64'd4) : 64'd0;
        mp  = ev && (t != m_br.pred);
        chk("req_ready", req_ready, !m_eval && (m_flush_left == 0) && !flush_in);
        chk("resolve_valid", resolve_valid, ev);
        chk("resolve_taken", resolve_taken, t);
        chk("resolve_target", resolve_target, tgt);
        chk("redirect_valid", redirect_valid, mp);
        chk("redirect_pc", redirect_pc, mp ? tgt : 64'd0);
        chk("flush_out", flush_out, m_flush_left > 0);
        chk("illegal_op", illegal_op, ev && (m_br.f3 == 3'd2 || m_br.f3 == 3'd3));
        chk("misalign", misalign, t && ((tgt >> 1) & 64'd1) != 0);
        chk("stat_branches", stat_branches, STATS_EN ? m_nbr : 0);
        chk("stat_mispred", stat_mispred, STATS_EN ? m_nmp : 0);
    end

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
    endtask

    task automatic issue(input logic [63:0] rs1, input logic [63:0] rs2, input logic [2:0] f3,
                         input logic [63:0] pc, input logic [63:0] imm, input logic pred);
        req_rs1 = rs1; req_rs2 = rs2; req_funct3 = f3;
        req_pc = pc; req_imm = imm; req_pred_taken = pred;
        flush_in  = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_last_acc) break;
        end
        checks++;
        if (!m_last_acc) begin
            errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept at %0t", $time);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (!m_eval && m_flush_left == 0) break;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [12:0] b;
        rst_n = 1'b0; req_valid = 1'b0; flush_in = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_funct3 = '0; req_pc = '0; req_imm = '0; req_pred_taken = 1'b0;
        model_reset();
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resolve_target", resolve_target, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_flush_out", flush_out, 0);
        tick();
        rst_n = 1'b1;

        // BEQ taken, predicted taken
        issue(64'h5, 64'h5, 3'b000, 64'h1000, 64'h40, 1'b1);
        @(negedge clk);
        chk("beq_resolve_valid", resolve_valid, 1);
        chk("beq_taken", resolve_taken, 1);
        chk("beq_target", resolve_target, 64'h1040);
        chk("beq_no_redirect", redirect_valid, 0);
        tick();
        @(negedge clk);
        chk("beq_ready_acc2", req_ready, 1);

        // BLT signed taken, predicted not taken
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b100, 64'h2000, 64'h100, 1'b0);
        @(negedge clk);
        chk("blt_taken", resolve_taken, 1);
        chk("blt_redirect", redirect_valid, 1);
        chk("blt_redirect_pc", redirect_pc, 64'h2100);
        tick(); @(negedge clk);
        chk("blt_flush1", flush_out, 1);
        chk("blt_ready1", req_ready, 0);
        tick(); @(negedge clk);
        chk("blt_flush2", flush_out, 1);
        chk("blt_ready2", req_ready, 0);
        tick(); @(negedge clk);
        chk("blt_flush_end", flush_out, 0);
        chk("blt_ready_acc4", req_ready, 1);

        // BLTU not taken, predicted taken
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b110, 64'h3000, 64'h80, 1'b1);
        @(negedge clk);
        chk("bltu_taken", resolve_taken, 0);
        chk("bltu_redirect_pc", redirect_pc, 64'h3004);
        drain();

        // fall-through past the top of the address space
        issue(64'h1, 64'h2, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1'b0);
        @(negedge clk);
        chk("wrap_valid", resolve_valid, 1);
        chk("wrap_target", resolve_target, 64'h0);
        chk("wrap_no_redirect", redirect_valid, 0);
        drain();

        issue(64'h3, 64'h3, 3'b011, 64'h4000, 64'h20, 1'b1);
        @(negedge clk);
        chk("ill_op", illegal_op, 1);
        chk("ill_resolve", resolve_valid, 1);
        chk("ill_taken", resolve_taken, 0);
        chk("ill_redirect_pc", redirect_pc, 64'h4004);
        drain();

        // external flush during EVAL of a mispredicting BNE
        issue(64'h1, 64'h2, 3'b001, 64'h5000, 64'h10, 1'b0);
        flush_in = 1'b1;
        @(negedge clk);
        chk("fin_no_resolve", resolve_valid, 0);
        chk("fin_no_redirect", redirect_valid, 0);
        tick();
        flush_in = 1'b0;
        @(negedge clk);
        chk("fin_idle_ready", req_ready, 1);
        chk("fin_no_flush", flush_out, 0);
        chk("fin_stat_br", stat_branches, STATS_EN ? 5 : 0);
        chk("fin_stat_mp", stat_mispred, STATS_EN ? 3 : 0);

        // asynchronous reset in the middle of a flush
        issue(64'h7, 64'h7, 3'b000, 64'h6000, 64'h8, 1'b0);
        tick(); @(negedge clk);
        chk("rstm_flush_before", flush_out, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rstm_flush_drop", flush_out, 0);
        chk("rstm_ready", req_ready, 1);
        chk("rstm_stat_br", stat_branches, 0);
        tick();
        rst_n = 1'b1;

        issue(64'h5, 64'h5, 3'b000, 64'h100, 64'h10, 1'b1); drain();
        issue(64'h5, 64'h6, 3'b001, 64'h100, 64'h10, 1'b1); drain();
        issue(64'h5, 64'h6, 3'b000, 64'h100, 64'h10, 1'b1); drain();
        @(negedge clk);
        chk("stat3_br", stat_branches, STATS_EN ? 3 : 0);
        chk("stat3_mp", stat_mispred, STATS_EN ? 1 : 0);
        for (int i = 0; i < 16; i++) begin
            issue(64'h5, 64'h5, 3'b000, 64'h100, 64'h10, 1'b0);
            drain();
        end
        @(negedge clk);
        chk("sat_br", stat_branches, STATS_EN ? CNT_MAX : 0);
        chk("sat_mp", stat_mispred, STATS_EN ? CNT_MAX : 0);

        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            flush_in   = ($urandom_range(0, 15) == 0);
            req_funct3 = 3'($urandom_range(0, 7));
            req_rs1    = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       req_rs2 = req_rs1;
                1:       req_rs2 = req_rs1 ^ 64'h8000_0000_0000_0000;
                default: req_rs2 = {$urandom, $urandom};
            endcase
            req_pc = {$urandom, $urandom};
            b = 13'($urandom);
            req_imm = ($urandom_range(0, 1) == 1) ? {{51{b[12]}}, b[12:1], 1'b0} : {$urandom, $urandom};
            req_pred_taken = ($urandom_range(0, 1) == 1);
            tick();
        end
        req_valid = 1'b0;
        flush_in  = 1'b0;
        drain();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
